// File: rtl/ln_special_bypass_pkg.sv
// Floating-point format helpers shared by the ln wrapper: field widths,
// special-value bit patterns and the operand class tag carried beside the core.
package fp_precision_pkg;

  // Operand class; the tag FIFO stores this 3-bit code.
  typedef enum logic [2:0] {
    NORMAL = 3'd0,
    ZERO   = 3'd1,
    NEG    = 3'd2,
    PINF   = 3'd3,
    NAN    = 3'd4,
    ONE    = 3'd5
  } ln_class_e;

  function automatic int exp_bits(input string p);
    if (p == "SINGLE") return 8;
    else if (p == "DOUBLE") return 11;
    return 5;
  endfunction

  function automatic int man_bits(input string p);
    if (p == "SINGLE") return 23;
    else if (p == "DOUBLE") return 52;
    return 10;
  endfunction

  // +1.0: biased exponent equal to the bias, zero mantissa.
  function automatic logic [63:0] pos_one_bits(input string p);
    logic [63:0] bias;
    bias = (64'd1 << (exp_bits(p) - 1)) - 64'd1;
    return bias << man_bits(p);
  endfunction

  // +inf: exponent all ones, zero mantissa.
  function automatic logic [63:0] pos_inf_bits(input string p);
    return ((64'd1 << exp_bits(p)) - 64'd1) << man_bits(p);
  endfunction

  // -inf: +inf with the sign bit set.
  function automatic logic [63:0] neg_inf_bits(input string p);
    return pos_inf_bits(p) | (64'd1 << (exp_bits(p) + man_bits(p)));
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] qnan_bits(input string p);
    return pos_inf_bits(p) | (64'd1 << (man_bits(p) - 1));
  endfunction

endpackage

// File: rtl/ln_tag_fifo.sv
// In-order class-tag FIFO. Push and pop may coincide at any occupancy; a push
// into a full FIFO is dropped unless a pop frees the slot in the same cycle,
// and a pop from an empty FIFO is ignored (the pushed tag is never bypassed).
module ln_tag_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers (wrap modulo DEPTH) and entry count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop) rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      case ({do_push, do_pop})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ln_special_bypass.sv
// Special-value wrapper around a fixed-latency ln core. Operands are classified
// on entry; specials are replaced by +1.0 toward the core and their class rides
// in an in-order tag FIFO. On each core result the tag is popped and the
// IEEE-correct special result substituted.
// Strobe semantics: in_valid, core_in_valid, core_out_valid and out_valid are
// single-cycle qualifiers of their data; there is no ready/backpressure.
module ln_special_bypass
  import fp_precision_pkg::*;
#(
  parameter int    BITS      = 16,
  parameter string PRECISION = "HALF",
  parameter int    DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [BITS-1:0]          a,
  output logic                     core_in_valid,
  output logic [BITS-1:0]          core_a,
  input  logic                     core_out_valid,
  input  logic [BITS-1:0]          core_c,
  output logic                     out_valid,
  output logic [BITS-1:0]          c,
  output logic                     tag_overflow,
  output logic                     tag_underflow,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int EB = exp_bits(PRECISION);
  localparam int MB = man_bits(PRECISION);

  localparam logic [BITS-1:0] K_ONE  = BITS'(pos_one_bits(PRECISION));
  localparam logic [BITS-1:0] K_PINF = BITS'(pos_inf_bits(PRECISION));
  localparam logic [BITS-1:0] K_NINF = BITS'(neg_inf_bits(PRECISION));
  localparam logic [BITS-1:0] K_QNAN = BITS'(qnan_bits(PRECISION));

  // Priority: NaN, zero/subnormal, negative, +inf, exact 1.0, normal.
  function automatic ln_class_e classify(input logic [BITS-1:0] x);
    logic [EB-1:0] e;
    logic [MB-1:0] m;
    ln_class_e     cls;
    e = x[BITS-2 -: EB];
    m = x[MB-1:0];
    if (&e && |m)            cls = NAN;
    else if (e == '0)        cls = ZERO;
    else if (x[BITS-1])      cls = NEG;
    else if (&e)             cls = PINF;
    else if (x == K_ONE)     cls = ONE;
    else                     cls = NORMAL;
    return cls;
  endfunction

  function automatic logic [BITS-1:0] map_result(input ln_class_e cls,
                                                 input logic [BITS-1:0] r);
    logic [BITS-1:0] res;
    case (cls)
      NAN, NEG: res = K_QNAN;
      ZERO:     res = K_NINF;
      PINF:     res = K_PINF;
      ONE:      res = '0;
      default:  res = r;
    endcase
    return res;
  endfunction

  ln_class_e  in_cls;
  ln_class_e  pop_cls;
  logic [2:0] tag_dout;
  logic       tag_full;
  logic       tag_empty;

  assign in_cls = classify(a);

  ln_tag_fifo #(
    .W     (3),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (in_valid),
    .din   (in_cls),
    .pop   (core_out_valid),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty),
    .count (occupancy)
  );

  // An empty FIFO on pop means the result has no tag: pass it through.
  always_comb begin
    pop_cls = NORMAL;
    if (!tag_empty) pop_cls = ln_class_e'(tag_dout);
  end

  // Input stage: forward the operand, replacing specials with +1.0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_in_valid <= 1'b0;
      core_a        <= '0;
    end else begin
      core_in_valid <= in_valid;
      core_a        <= (in_cls == NORMAL) ? a : K_ONE;
    end
  end

  // Output stage: substitute the special result selected by the popped tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      c         <= '0;
    end else begin
      out_valid <= core_out_valid;
      c         <= map_result(pop_cls, core_c);
    end
  end

  // Sticky FIFO misuse flags, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_overflow  <= 1'b0;
      tag_underflow <= 1'b0;
    end else begin
      if (in_valid && tag_full && !core_out_valid) tag_overflow <= 1'b1;
      if (core_out_valid && tag_empty)             tag_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ln_special_bypass.sv
// Bench for ln_special_bypass (HALF). A 5-cycle stub core returning 16'h398C
// feeds the DEPTH=16 instance; a DEPTH=4 instance is driven by hand.
module tb_ln_special_bypass;
  import fp_precision_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DEPTH=16 instance + stub core ----------------
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic        core_in_valid;
  logic [15:0] core_a;
  logic        core_out_valid;
  logic [15:0] core_c;
  logic        out_valid;
  logic [15:0] c;
  logic        tag_overflow;
  logic        tag_underflow;
  logic [4:0]  occupancy;

  logic        stall = 1'b0;
  logic        man_v = 1'b0;
  logic [15:0] man_c = '0;
  logic [4:0]  pipe  = '0;

  always @(posedge clk) pipe <= {pipe[3:0], core_in_valid};
  assign core_out_valid = stall ? man_v : pipe[4];
  assign core_c         = stall ? man_c : 16'h398C;

  ln_special_bypass #(.BITS(16), .PRECISION("HALF"), .DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .a(a),
    .core_in_valid(core_in_valid), .core_a(core_a),
    .core_out_valid(core_out_valid), .core_c(core_c),
    .out_valid(out_valid), .c(c),
    .tag_overflow(tag_overflow), .tag_underflow(tag_underflow),
    .occupancy(occupancy)
  );

  // ---------------- DEPTH=4 instance ----------------
  logic        d4_in_valid = 1'b0;
  logic [15:0] d4_a = '0;
  logic        d4_core_in_valid;
  logic [15:0] d4_core_a;
  logic        d4_core_out_valid = 1'b0;
  logic [15:0] d4_core_c = '0;
  logic        d4_out_valid;
  logic [15:0] d4_c;
  logic        d4_tag_overflow;
  logic        d4_tag_underflow;
  logic [2:0]  d4_occupancy;

  ln_special_bypass #(.BITS(16), .PRECISION("HALF"), .DEPTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(d4_in_valid), .a(d4_a),
    .core_in_valid(d4_core_in_valid), .core_a(d4_core_a),
    .core_out_valid(d4_core_out_valid), .core_c(d4_core_c),
    .out_valid(d4_out_valid), .c(d4_c),
    .tag_overflow(d4_tag_overflow), .tag_underflow(d4_tag_underflow),
    .occupancy(d4_occupancy)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] core_q[$];
  int occ_max = 0;
  logic scb_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ln special-case result for a half operand.
  function automatic logic [15:0] model_c(input logic [15:0] x, input logic [15:0] r);
    logic [4:0] e;
    logic [9:0] m;
    e = x[14:10];
    m = x[9:0];
    if (e == 5'h1F && m != 0) return 16'h7E00;
    if (e == 5'h00)           return 16'hFC00;
    if (x[15])                return 16'h7E00;
    if (e == 5'h1F)           return 16'h7C00;
    if (x == 16'h3C00)        return 16'h0000;
    return r;
  endfunction

  function automatic logic [15:0] model_core_a(input logic [15:0] x);
    if (x[14:10] == 5'h00 || x[14:10] == 5'h1F || x[15] || x == 16'h3C00) return 16'h3C00;
    return x;
  endfunction

  // Monitor: compare every core operand and every final result in order.
  always @(negedge clk) begin
    if (rstn && scb_en) begin
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      if (core_in_valid) begin
        check("core_q_nonempty", 32'(core_q.size() != 0), 32'd1);
        if (core_q.size() != 0) check("core_a", 32'(core_a), 32'(core_q.pop_front()));
      end
      if (out_valid) begin
        check("out_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("c", 32'(c), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [15:0] v);
    in_valid = 1'b1;
    a        = v;
    exp_q.push_back(model_c(v, 16'h398C));
    core_q.push_back(model_core_a(v));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] batch [7];
  logic [15:0] d4_pops [4];
  int lat;

  initial begin
    batch   = '{16'h0000, 16'h8000, 16'h0001, 16'hC000, 16'h7C00, 16'h7E01, 16'h3C00};
    d4_pops = '{16'hFC00, 16'h7C00, 16'h0000, 16'h7E00};

    // Reset values while rstn is held low.
    idle(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_core_in_valid", 32'(core_in_valid), 32'd0);
    check("rst_core_a", 32'(core_a), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_flags", 32'({tag_overflow, tag_underflow}), 32'd0);
    rstn = 1'b1;
    idle(2);

    // Single normal operand: core sees it unchanged, result after 7 cycles.
    send(16'h4000);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd7);
    idle(3);

    // Back-to-back special operands.
    foreach (batch[i]) send(batch[i]);
    idle(12);
    check("batch_drained", 32'(exp_q.size()), 32'd0);

    // Alternating normal / zero for 64 cycles.
    occ_max = 0;
    for (int i = 0; i < 32; i++) begin
      send(16'h4000);
      send(16'h0000);
    end
    idle(12);
    check("interleave_drained", 32'(exp_q.size()), 32'd0);
    check("interleave_occ_le6", 32'(occ_max <= 6), 32'd1);
    check("interleave_flags", 32'({tag_overflow, tag_underflow}), 32'd0);
    check("interleave_occ_end", 32'(occupancy), 32'd0);

    // DEPTH=4: fill, push+pop at full, overflow, drain in order.
    d4_in_valid = 1'b1;
    d4_a = 16'h4000; @(negedge clk);
    check("d4_core_a", 32'(d4_core_a), 32'h4000);
    d4_a = 16'h0000; @(negedge clk);
    d4_a = 16'h7C00; @(negedge clk);
    d4_a = 16'h3C00; @(negedge clk);
    check("d4_full_occ", 32'(d4_occupancy), 32'd4);
    check("d4_full_no_ovf", 32'(d4_tag_overflow), 32'd0);
    d4_a = 16'hC000; d4_core_out_valid = 1'b1; d4_core_c = 16'h5555;
    @(negedge clk);
    check("d4_pp_valid", 32'(d4_out_valid), 32'd1);
    check("d4_pp_c", 32'(d4_c), 32'h5555);
    check("d4_pp_occ", 32'(d4_occupancy), 32'd4);
    check("d4_pp_no_ovf", 32'(d4_tag_overflow), 32'd0);
    d4_a = 16'h7E01; d4_core_out_valid = 1'b0;
    @(negedge clk);
    check("d4_ovf", 32'(d4_tag_overflow), 32'd1);
    check("d4_ovf_occ", 32'(d4_occupancy), 32'd4);
    d4_in_valid = 1'b0; d4_core_out_valid = 1'b1; d4_core_c = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("d4_pop_c", 32'(d4_c), 32'(d4_pops[i]));
    end
    d4_core_out_valid = 1'b0;
    check("d4_drain_occ", 32'(d4_occupancy), 32'd0);
    check("d4_no_udf", 32'(d4_tag_underflow), 32'd0);

    // Core result with the FIFO empty.
    stall = 1'b1;
    man_c = 16'h1234;
    man_v = 1'b1;
    exp_q.push_back(16'h1234);
    @(negedge clk);
    man_v = 1'b0;
    idle(1);
    check("udf_flag", 32'(tag_underflow), 32'd1);
    check("udf_drained", 32'(exp_q.size()), 32'd0);
    stall = 1'b0;
    idle(2);

    // Asynchronous reset with three tags in flight.
    send(16'h0000);
    send(16'h0000);
    send(16'h0000);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_core_in_valid", 32'(core_in_valid), 32'd0);
    check("arst_core_a", 32'(core_a), 32'd0);
    check("arst_occupancy", 32'(occupancy), 32'd0);
    check("arst_flags", 32'({tag_overflow, tag_underflow}), 32'd0);
    check("arst_c", 32'(c), 32'd0);
    check("arst_d4_flags", 32'({d4_tag_overflow, d4_tag_underflow}), 32'd0);
    exp_q.delete();
    core_q.delete();
    repeat (3) exp_q.push_back(16'h398C);
    #1 rstn = 1'b1;
    idle(12);
    check("late_udf", 32'(tag_underflow), 32'd1);
    check("late_drained", 32'(exp_q.size()), 32'd0);
    check("late_occ", 32'(occupancy), 32'd0);

    scb_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ln_special_bypass.md
Name: ln_special_bypass

Overview:
- Wrapper stage placed around the fixed-latency ln datapath; it feeds the core and consumes its result.
- Classifies each IEEE operand on entry: zero, subnormal, negative, +inf, NaN or exact 1.0.
- Forwards a sanitised operand to the core and carries a class tag in an in-order tag FIFO.
- On core result return, pops the tag and substitutes the IEEE-correct special result where required; otherwise passes the core result through.

Parameters:
- BITS, 16, operand/result width; must match PRECISION.
- PRECISION, "HALF", "HALF" (1/5/10), "SINGLE" (1/8/23) or "DOUBLE" (1/11/52).
- DEPTH, 16, tag FIFO entries; power of two, at least 2, at least the core's maximum in-flight count.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  operand strobe; no backpressure.
- a  input  BITS  operand.
- core_in_valid  output  1  strobe to ln core.
- core_a  output  BITS  sanitised operand to ln core.
- core_out_valid  input  1  ln core result strobe.
- core_c  input  BITS  ln core result.
- out_valid  output  1  final result strobe.
- c  output  BITS  final result.
- tag_overflow  output  1  sticky: push attempted while FIFO full.
- tag_underflow  output  1  sticky: core result arrived with FIFO empty.
- occupancy  output  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset is asynchronous on rstn low. All of the following clear to 0: out_valid, c, tag_overflow, tag_underflow, occupancy, FIFO pointers, core_in_valid, core_a.
- Reset mid-operation discards every in-flight tag. Core results arriving after reset release with an empty FIFO raise tag_underflow.
- Input stage (1 register):
  - core_in_valid <= in_valid.
  - core_a <= a for class NORMAL; core_a <= +1.0 for every other class, so the core never sees special operands.
  - Tag pushed in the same cycle that in_valid is sampled.
- Class encoding, 3 bits, with priority in this order:
  - NAN: exp all ones, mantissa != 0.
  - ZERO: exp == 0, sign ignored; subnormals are flushed to ZERO.
  - NEG: sign = 1.
  - PINF: exp all ones, mantissa == 0.
  - ONE: bit pattern equals +1.0.
  - NORMAL: everything else.
- Result mapping, applied on pop:
  - NAN and NEG give canonical quiet NaN: sign 0, exp all ones, mantissa MSB 1, rest 0.
  - ZERO gives -inf.
  - PINF gives +inf.
  - ONE gives +0.
  - NORMAL gives core_c unchanged.
- Output stage (1 register):
  - out_valid <= core_out_valid.
  - c <= mapped value.
  - Total latency = core latency + 2 cycles. Results leave in input order.
- FIFO rules:
  - Push on in_valid; pop on core_out_valid.
  - Push and pop in the same cycle: allowed at any occupancy, including full and empty. When empty, the pushed tag is not bypassed to the same-cycle pop; underflow rules apply.
  - Push while full without a simultaneous pop: tag dropped, tag_overflow set, FIFO contents unchanged.
  - Pop while empty: c = core_c (treated as NORMAL), out_valid still asserted, tag_underflow set.
  - Sticky flags clear only on reset.
  - Pointers wrap modulo DEPTH. occupancy is in the range 0..DEPTH.

Decomposition:
- Package fp_precision_pkg holds:
  - Functions exp_bits(PRECISION) and man_bits(PRECISION).
  - Constant builders for +1.0, +inf, -inf and canonical qNaN per precision.
  - Typedef ln_class_e (3-bit enum: NORMAL, ZERO, NEG, PINF, NAN, ONE).
- One sub-module: ln_tag_fifo (synchronous FIFO, width 3, depth DEPTH, with full/empty/count). Classification and mapping stay in the top level as combinational functions.

Test Plan:
- HALF, stub core of latency 5 returning 16'h398C. Input a=16'h4000 (2.0) -> core_a=16'h4000; out_valid 7 cycles later with c=16'h398C.
- Back-to-back inputs 16'h0000, 16'h8000, 16'h0001, 16'hC000, 16'h7C00, 16'h7E01, 16'h3C00 -> c = FC00, FC00, FC00, 7E00, 7C00, 7E00, 0000 in order. Each of these sends core_a=16'h3C00.
- Interleave 2.0 and 0.0 every cycle for 64 cycles -> outputs alternate 398C/FC00, occupancy stays ≤ 6, no flags raised.
- DEPTH=4, core stalled (no core_out_valid), 5 consecutive inputs -> occupancy=4, tag_overflow=1 after the 5th input. With DEPTH=4 and occupancy=4, a push with a simultaneous pop -> no overflow, occupancy stays 4.
- core_out_valid pulsed with FIFO empty, core_c=16'h1234 -> out_valid=1, c=16'h1234, tag_underflow=1.
- Assert rstn low with 3 tags in flight -> all outputs 0 immediately (asynchronous). The 3 late core results after release -> tag_underflow=1, and each c equals its core_c.
